imem_sync: RTL and testbench

Parametrised, clocked instruction memory that replaces the combinational word-addressed fetch array. It accepts byte addresses over a valid/ready request channel and returns the instruction one cycle later over a valid/ready response channel that supports backpressure. It includes a write port for program loading during test or boot. It sits between the PC/fetch stage and the decode stage.

---
 rtl/imem_sync_if.sv | 42 ++++
 rtl/imem_sync.sv | 112 +++++++++++
 tb/tb_imem_sync.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_sync_if.sv
// imem_sync_if: fetch request/response handshake, program-load port and
// debug state for the clocked instruction memory imem_sync.
//
// Handshake rules (both channels use the same rules):
//   - A transfer happens on the rising clock edge where valid && ready.
//   - A producer holds its valid signal, and the payload that goes with it,
//     until the transfer takes place.
//   - ready may depend on valid in the same cycle. valid must never depend
//     on ready.
//   - Request channel:  ReqValid / ReqReady, payload Address.
//   - Response channel: RespValid / RespReady, payload Instruction and Fault.
// The load port (LoadEn/LoadAddress/LoadData) has no handshake. It is never
// stalled.
interface imem_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  ReqValid;
    logic                  ReqReady;
    logic [ADDR_WIDTH-1:0] Address;
    logic                  RespValid;
    logic                  RespReady;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  Fault;
    logic                  LoadEn;
    logic [ADDR_WIDTH-1:0] LoadAddress;
    logic [DATA_WIDTH-1:0] LoadData;
    // Debug view of the response-slot state: 0 = EMPTY, 1 = FULL.
    logic                  DbgState;

    // The fetch stage, consumer and loader side.
    modport master (
        output ReqValid, Address, RespReady, LoadEn, LoadAddress, LoadData,
        input  ReqReady, RespValid, Instruction, Fault, DbgState
    );

    // The memory side.
    modport slave (
        input  ReqValid, Address, RespReady, LoadEn, LoadAddress, LoadData,
        output ReqReady, RespValid, Instruction, Fault, DbgState
    );
endinterface

// File: rtl/imem_sync.sv
// imem_sync: clocked instruction memory with a one-deep response pipeline.
// Byte addresses arrive on a valid/ready request channel. The addressed word
// returns one cycle later on a valid/ready response channel, which supports
// backpressure. A separate, unstalled load port writes program words.
//
// Optional feature, macro IMEM_FAULT_EN:
//   - Defined: misaligned or out-of-range fetches return Fault=1 with
//     Instruction=0, and out-of-range loads are dropped.
//   - Undefined: Fault is always 0, and addresses wrap on DEPTH_LOG2 index bits.
module imem_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int BYTE_SHIFT = 2
) (
    input  logic         Clock,
    input  logic         ResetN,
    imem_sync_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef IMEM_FAULT_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << BYTE_SHIFT) - 1);
    localparam int INDEX_TOP = DEPTH_LOG2 + BYTE_SHIFT;
`endif

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // The memory is never reset. Its contents survive ResetN.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  fault_q, fault_d;

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  accept;
    logic                  rd_fault;
    logic                  wr_ok;
    // Address bits outside the word index feed only the optional checks.
    logic                  unused_addr_bits;

    assign rd_idx = DEPTH_LOG2'(bus.Address >> BYTE_SHIFT);
    assign wr_idx = DEPTH_LOG2'(bus.LoadAddress >> BYTE_SHIFT);
    assign unused_addr_bits = ^{bus.Address, bus.LoadAddress};

    // A new request may enter when the slot is free, or when it is being
    // emptied on this same edge.
    assign bus.ReqReady = (state_q == EMPTY) || bus.RespReady;
    assign accept       = bus.ReqValid && bus.ReqReady;

    // Address checks for the optional fault feature.
    always_comb begin
`ifdef IMEM_FAULT_EN
        rd_fault = ((bus.Address & ALIGN_MASK) != '0) ||
                   ((bus.Address >> INDEX_TOP) != '0);
        wr_ok    = ((bus.LoadAddress >> INDEX_TOP) == '0);
`else
        rd_fault = 1'b0;
        wr_ok    = 1'b1;
`endif
    end

    // Next-state and response-register logic for the EMPTY/FULL slot.
    // The memory is read combinationally here, and the load write below
    // lands at the same edge. So a same-edge fetch of the word being loaded
    // captures the old contents (read-first).
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (accept) begin
            state_d = FULL;
            fault_d = rd_fault;
            instr_d = rd_fault ? '0 : mem[rd_idx];
        end else if ((state_q == FULL) && bus.RespReady) begin
            // Drain: the response leaves and Instruction keeps its last value.
            state_d = EMPTY;
        end
    end

    // Response slot state and payload registers, cleared asynchronously.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= EMPTY;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Program-load write port. It is independent of the fetch handshake.
    always_ff @(posedge Clock) begin
        if (bus.LoadEn && wr_ok) begin
            mem[wr_idx] <= bus.LoadData;
        end
    end

    assign bus.RespValid   = (state_q == FULL);
    assign bus.Instruction = instr_q;
    assign bus.Fault       = fault_q;
    assign bus.DbgState    = state_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed and random test of imem_sync.
// A negedge monitor keeps a reference copy of memory. It pushes each
// expected {Fault, Instruction} when a request is accepted and pops it when
// the response handshakes. It also checks latency, hold and ReqReady.
// Compile with IMEM_FAULT_EN defined to exercise the fault variant.
module tb_imem_sync;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk;
    logic rst_n;

    imem_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    imem_sync #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH_LOG2(10),
        .BYTE_SHIFT(2)
    ) dut (
        .Clock  (clk),
        .ResetN (rst_n),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] model_mem [0:1023];

    logic          acc_prev   = 1'b0;
    logic          hold_prev  = 1'b0;
    logic [DW-1:0] instr_prev = '0;
    logic          fault_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result of a fetch: {Fault, Instruction}.
    function automatic logic [DW:0] expect_of(input logic [AW-1:0] a);
        logic f;
        f = 1'b0;
`ifdef IMEM_FAULT_EN
        f = (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
`endif
        return f ? {1'b1, {DW{1'b0}}} : {1'b0, model_mem[a[11:2]]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_prev  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (acc_prev)
                chk("latency", 64'(bus.RespValid), 64'(1));
            if (hold_prev) begin
                chk("hold_valid", 64'(bus.RespValid), 64'(1));
                chk("hold_instr", 64'(bus.Instruction), 64'(instr_prev));
                chk("hold_fault", 64'(bus.Fault), 64'(fault_prev));
            end
            chk("req_ready", 64'(bus.ReqReady), 64'(!bus.RespValid || bus.RespReady));
            if (bus.RespValid)
                chk("resp_expected", 64'(exp_q.size() != 0), 64'(1));
            if (bus.RespValid && bus.RespReady && exp_q.size() != 0) begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("resp", 64'({bus.Fault, bus.Instruction}), 64'(e));
            end
            acc_prev = bus.ReqValid && bus.ReqReady;
            if (acc_prev)
                exp_q.push_back(expect_of(bus.Address));
            hold_prev  = bus.RespValid && !bus.RespReady;
            instr_prev = bus.Instruction;
            fault_prev = bus.Fault;
            // The load lands on the coming edge, after the fetch above read the old value.
            if (bus.LoadEn) begin
`ifdef IMEM_FAULT_EN
                if (bus.LoadAddress[31:12] == 20'h0)
                    model_mem[bus.LoadAddress[11:2]] = bus.LoadData;
`else
                model_mem[bus.LoadAddress[11:2]] = bus.LoadData;
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.LoadEn      = 1'b1;
        bus.LoadAddress = a;
        bus.LoadData    = d;
        cyc();
        bus.LoadEn      = 1'b0;
    endtask

    // Present a request and hold it until accepted. The task returns #1 after
    // the accepting edge, when the response is already visible.
    task automatic fetch(input logic [AW-1:0] a);
        bit got;
        got = 1'b0;
        bus.ReqValid = 1'b1;
        bus.Address  = a;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.ReqReady;
            if (!got) @(posedge clk);
        end
        if (got) cyc();
        bus.ReqValid = 1'b0;
        chk("accept_in_time", 64'(got), 64'(1));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bus.ReqValid    = 1'b0;
        bus.Address     = '0;
        bus.RespReady   = 1'b1;
        bus.LoadEn      = 1'b0;
        bus.LoadAddress = '0;
        bus.LoadData    = '0;
        rst_n           = 1'b0;

        // Reset state.
        #3;
        chk("rst_valid", 64'(bus.RespValid), 64'(0));
        chk("rst_instr", 64'(bus.Instruction), 64'(0));
        chk("rst_fault", 64'(bus.Fault), 64'(0));
        chk("rst_state", 64'(bus.DbgState), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // 1: program load, then four back-to-back fetches.
        load(32'h0, 32'hFC000003);
        load(32'h4, 32'hFC200005);
        load(32'h8, 32'h00600824);
        load(32'hC, 32'h00800825);
        load(32'h10, 32'h00000020);
        load(32'h14, 32'h00000055);
        load(32'h18, 32'h66666666);
        load(32'h1C, 32'h77777777);
        fetch(32'h0); chk("t1_w0", 64'(bus.Instruction), 64'(32'hFC000003));
        fetch(32'h4); chk("t1_w1", 64'(bus.Instruction), 64'(32'hFC200005));
        fetch(32'h8); chk("t1_w2", 64'(bus.Instruction), 64'(32'h00600824));
        fetch(32'hC); chk("t1_w3", 64'(bus.Instruction), 64'(32'h00800825));
        cyc();

        // 2: backpressure holds the response and blocks a new request.
        bus.RespReady = 1'b0;
        fetch(32'h4);
        chk("t2_first", 64'(bus.Instruction), 64'(32'hFC200005));
        bus.ReqValid = 1'b1;
        bus.Address  = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_ready_low", 64'(bus.ReqReady), 64'(0));
            chk("t2_valid_hold", 64'(bus.RespValid), 64'(1));
            chk("t2_instr_hold", 64'(bus.Instruction), 64'(32'hFC200005));
            cyc();
        end
        bus.RespReady = 1'b1;
        @(negedge clk);
        chk("t2_ready_back", 64'(bus.ReqReady), 64'(1));
        cyc();
        bus.ReqValid = 1'b0;
        chk("t2_next", 64'(bus.Instruction), 64'(32'h00600824));
        chk("t2_next_valid", 64'(bus.RespValid), 64'(1));
        cyc();
        chk("t2_drain_valid", 64'(bus.RespValid), 64'(0));
        chk("t2_drain_keep", 64'(bus.Instruction), 64'(32'h00600824));

        // 3: same-edge load and fetch of one word reads the old contents.
        bus.LoadEn      = 1'b1;
        bus.LoadAddress = 32'h10;
        bus.LoadData    = 32'hDEADBEEF;
        bus.ReqValid    = 1'b1;
        bus.Address     = 32'h10;
        cyc();
        bus.LoadEn   = 1'b0;
        bus.ReqValid = 1'b0;
        chk("t3_old", 64'(bus.Instruction), 64'(32'h00000020));
        fetch(32'h10);
        chk("t3_new", 64'(bus.Instruction), 64'(32'hDEADBEEF));
        cyc();

        // 4: reset with a response pending discards it; memory survives.
        bus.RespReady = 1'b0;
        fetch(32'h8);
        chk("t4_pending", 64'(bus.RespValid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(bus.RespValid), 64'(0));
        chk("t4_rst_instr", 64'(bus.Instruction), 64'(0));
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.RespReady = 1'b1;
        repeat (3) cyc();
        chk("t4_no_stale", 64'(bus.RespValid), 64'(0));
        fetch(32'h8);
        chk("t4_preserved", 64'(bus.Instruction), 64'(32'h00600824));
        cyc();

        // 5: misaligned and out-of-range fetches, and wrapping loads.
        fetch(32'h6);
`ifdef IMEM_FAULT_EN
        chk("t5_mis_fault", 64'(bus.Fault), 64'(1));
        chk("t5_mis_instr", 64'(bus.Instruction), 64'(0));
`else
        chk("t5_mis_fault", 64'(bus.Fault), 64'(0));
        chk("t5_mis_instr", 64'(bus.Instruction), 64'(32'hFC200005));
`endif
        fetch(32'h1000);
`ifdef IMEM_FAULT_EN
        chk("t5_oor_fault", 64'(bus.Fault), 64'(1));
        chk("t5_oor_instr", 64'(bus.Instruction), 64'(0));
`else
        chk("t5_oor_fault", 64'(bus.Fault), 64'(0));
        chk("t5_oor_instr", 64'(bus.Instruction), 64'(32'hFC000003));
`endif
        load(32'h1014, 32'h5A5A5A5A);
        fetch(32'h14);
`ifdef IMEM_FAULT_EN
        chk("t5_wrap_load", 64'(bus.Instruction), 64'(32'h00000055));
`else
        chk("t5_wrap_load", 64'(bus.Instruction), 64'(32'h5A5A5A5A));
`endif
        load(32'h1B, 32'h12345678);
        fetch(32'h18);
        chk("t5_low_bits", 64'(bus.Instruction), 64'(32'h12345678));
        cyc();

        // Random traffic with random backpressure over preloaded words 0..7.
        for (int i = 0; i < 80; i++) begin
            bus.ReqValid  = 1'($urandom_range(0, 1));
            bus.Address   = AW'($urandom_range(0, 7)) << 2;
            bus.RespReady = 1'($urandom_range(0, 1));
            cyc();
        end

        // Drain and make sure every accepted request produced its response.
        bus.ReqValid  = 1'b0;
        bus.RespReady = 1'b1;
        repeat (3) cyc();
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("end_state", 64'(bus.DbgState), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
